// File: rtl/store_buffer.sv
// Store buffer between the memory stage and the data bus.
// Aligns SB/SH/SW/SWL/SWR stores into a word plus byte strobe (little-endian),
// queues them in a DEPTH-entry FIFO and drains them in order over req/ready.
// Optionally coalesces a store into the tail entry when it targets the same word.
// Also flags misaligned stores and reports loads that hit a pending store's word.
module store_buffer #(
  parameter int DEPTH    = 4,     // power of two, >= 2
  parameter int ADDR_W   = 32,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_misalign,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_SH  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_SWL = 3'd3;
  localparam logic [2:0] OP_SWR = 3'd4;

  // Entry storage: word address, aligned data, strobe, valid flag.
  logic [WA_W-1:0]  ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_strb [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] last_ptr;   // most recently written entry
  logic [CNT_W-1:0] count;

  // Alignment results for the offered store.
  logic [1:0]      a;
  logic [31:0]     raw_data;
  logic [31:0]     al_data;
  logic [3:0]      al_strb;
  logic            al_legal;
  logic            al_misalign;
  logic [WA_W-1:0] st_word;

  logic xfer;
  logic do_merge;
  logic do_enq;
  logic do_deq;

  assign a        = st_addr[1:0];
  assign st_word  = st_addr[ADDR_W-1:2];
  assign last_ptr = tail_ptr - PTR_W'(1);

  // Shift the register value into its byte lanes and build the strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    al_strb     = 4'b0000;
    raw_data    = 32'h0;
    al_legal    = 1'b0;
    al_misalign = 1'b0;
    case (st_op)
      OP_SB: begin
        al_legal = 1'b1;
        al_strb  = 4'b0001 << a;
        raw_data = st_data << {a, 3'b000};
      end
      OP_SH: begin
        al_legal    = 1'b1;
        al_misalign = a[0];
        al_strb     = a[1] ? 4'b1100 : 4'b0011;
        raw_data    = a[1] ? (st_data << 16) : st_data;
      end
      OP_SW: begin
        al_legal    = 1'b1;
        al_misalign = (a != 2'b00);
        al_strb     = 4'b1111;
        raw_data    = st_data;
      end
      OP_SWL: begin
        // Left part: the top (a+1) bytes of rt land in lanes a..0.
        al_legal = 1'b1;
        al_strb  = 4'b1111 >> ~a;
        raw_data = st_data >> {~a, 3'b000};
      end
      OP_SWR: begin
        // Right part: the low (4-a) bytes of rt land in lanes 3..a.
        al_legal = 1'b1;
        al_strb  = 4'b1111 << a;
        raw_data = st_data << {a, 3'b000};
      end
      default: begin
        al_legal = 1'b0;
      end
    endcase
  end

  // Unwritten byte lanes are forced to zero.
  always_comb begin
    al_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (al_strb[i]) al_data[8*i +: 8] = raw_data[8*i +: 8];
    end
  end

  assign st_ready = (count != CNT_W'(DEPTH));
  assign xfer     = st_valid & st_ready;
  assign do_deq   = mem_req & mem_ready;

  // Merge only when at least two entries exist, so the tail is never the head
  // currently on the bus and a same-cycle drain cannot race the update.
  assign do_merge = MERGE_EN && xfer && al_legal && !al_misalign
                    && (count >= CNT_W'(2))
                    && (ent_addr[last_ptr] == st_word);
  assign do_enq   = xfer && al_legal && !al_misalign && !do_merge;

  // Pointers, occupancy, valid flags and the misalign pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      ent_valid   <= '0;
      st_misalign <= 1'b0;
    end else begin
      st_misalign <= xfer && al_legal && al_misalign;
      if (do_deq) begin
        ent_valid[head_ptr] <= 1'b0;
        head_ptr            <= head_ptr + PTR_W'(1);
      end
      if (do_enq) begin
        ent_valid[tail_ptr] <= 1'b1;
        tail_ptr            <= tail_ptr + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload: written on enqueue, byte-merged into the tail on coalesce.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays carry no reset; an entry is only observed while its
    // valid flag (which is reset) is set, and it is fully written before that.
    if (do_enq) begin
      ent_addr[tail_ptr] <= st_word;
      ent_data[tail_ptr] <= al_data;
      ent_strb[tail_ptr] <= al_strb;
    end else if (do_merge) begin
      ent_strb[last_ptr] <= ent_strb[last_ptr] | al_strb;
      for (int i = 0; i < 4; i++) begin
        if (al_strb[i]) ent_data[last_ptr][8*i +: 8] <= al_data[8*i +: 8];
      end
    end
  end

  assign mem_req   = (count != '0);
  assign empty     = (count == '0);
  assign mem_addr  = {ent_addr[head_ptr], 2'b00};
  assign mem_wdata = ent_data[head_ptr];
  assign mem_wstrb = ent_strb[head_ptr];

  // Load probe: word-granular match against every valid entry.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ld_addr[ADDR_W-1:2])) ld_conflict = 1'b1;
    end
  end

  // Byte offset of the load probe is irrelevant at word granularity.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, ADDR_W=32, MERGE_EN=1).
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misalign;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SWL = 3'd3, SWR = 3'd4;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .MERGE_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_op      (st_op),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_misalign(st_misalign),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .ld_addr    (ld_addr),
    .ld_conflict(ld_conflict),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one store for a single cycle; inputs change 1 time unit after the edge.
  task automatic push(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  // Hold mem_ready for exactly one edge.
  task automatic drain_one();
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    st_valid  = 1'b0;
    st_op     = SB;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ready = 1'b0;
    ld_addr   = 32'hFFFF_FFF0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",  {31'b0, mem_req},     32'd0);
    check("rst_empty",    {31'b0, empty},       32'd1);
    check("rst_st_ready", {31'b0, st_ready},    32'd1);
    check("rst_misalign", {31'b0, st_misalign}, 32'd0);
    reset = 1'b0;
    idle();

    // 1. SB to byte 3 of an empty buffer: visible on the bus the next cycle.
    push(SB, 32'h1234_5673, 32'h1122_3344);
    check("sb_mem_req", {31'b0, mem_req},   32'd1);
    check("sb_wstrb",   {28'b0, mem_wstrb}, 32'h8);
    check("sb_wdata",   mem_wdata,          32'h4400_0000);
    check("sb_addr",    mem_addr,           32'h1234_5670);
    drain_one();
    check("sb_drained", {31'b0, empty},     32'd1);

    // 2. SWL a=1 then SWR a=2 to the same word; count is 1 at the SWR so no merge.
    push(SWL, 32'h0000_0041, 32'hAABB_CCDD);
    push(SWR, 32'h0000_0042, 32'hAABB_CCDD);
    check("swl_wstrb", {28'b0, mem_wstrb}, 32'h3);
    check("swl_wdata", mem_wdata,          32'h0000_AABB);
    drain_one();
    check("swr_addr",  mem_addr,           32'h0000_0040);
    check("swr_wstrb", {28'b0, mem_wstrb}, 32'hC);
    check("swr_wdata", mem_wdata,          32'hCCDD_0000);
    drain_one();
    check("sw_lr_empty", {31'b0, empty},   32'd1);

    // 3. Fill to DEPTH with the bus stalled; a 5th store waits for one drain.
    for (int i = 0; i < 4; i++) push(SW, 32'h300 + 32'(i) * 32'h10, 32'hA0 + 32'(i));
    check("full_st_ready", {31'b0, st_ready}, 32'd0);
    st_valid = 1'b1;
    st_op    = SW;
    st_addr  = 32'h340;
    st_data  = 32'hA4;
    idle();
    check("full_held_ready", {31'b0, st_ready}, 32'd0);
    check("full_head",       mem_addr,          32'h300);
    check("full_head_data",  mem_wdata,         32'hA0);
    drain_one();
    check("after_drain_ready", {31'b0, st_ready}, 32'd1);
    check("after_drain_head",  mem_addr,          32'h310);
    idle();
    st_valid = 1'b0;
    check("refill_ready", {31'b0, st_ready}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("order_addr_%0d", i), mem_addr,  32'h300 + 32'(i) * 32'h10);
      check($sformatf("order_data_%0d", i), mem_wdata, 32'hA0 + 32'(i));
      drain_one();
    end
    check("fill_empty", {31'b0, empty}, 32'd1);

    // 4. Merge: SW 0x100, SB 0x104, SB 0x105 -> two entries, tail = 0011/0x6655.
    push(SW, 32'h100, 32'h0);
    push(SB, 32'h104, 32'h55);
    push(SB, 32'h105, 32'h66);
    check("merge_head_addr",  mem_addr,           32'h100);
    check("merge_head_strb",  {28'b0, mem_wstrb}, 32'hF);
    check("merge_head_data",  mem_wdata,          32'h0);
    drain_one();
    check("merge_tail_addr",  mem_addr,           32'h104);
    check("merge_tail_strb",  {28'b0, mem_wstrb}, 32'h3);
    check("merge_tail_data",  mem_wdata,          32'h0000_6655);
    drain_one();
    check("merge_count2",     {31'b0, empty},     32'd1);

    // 5. Misaligned SW and SH: one-cycle pulse, nothing queued. Illegal op: silent.
    push(SW, 32'h102, 32'hDEAD_BEEF);
    check("sw_mis_pulse", {31'b0, st_misalign}, 32'd1);
    check("sw_mis_empty", {31'b0, empty},       32'd1);
    idle();
    check("sw_mis_clear", {31'b0, st_misalign}, 32'd0);
    push(SH, 32'h101, 32'h1234);
    check("sh_mis_pulse", {31'b0, st_misalign}, 32'd1);
    check("sh_mis_empty", {31'b0, empty},       32'd1);
    idle();
    check("sh_mis_clear", {31'b0, st_misalign}, 32'd0);
    push(3'd6, 32'h0, 32'h1);
    check("illegal_flag",  {31'b0, st_misalign}, 32'd0);
    check("illegal_empty", {31'b0, empty},       32'd1);

    // 6. Load probe against a pending entry, then reset while it waits on the bus.
    push(SW, 32'h200, 32'h0BAD_F00D);
    ld_addr = 32'h203;
    #1;
    check("ld_hit",  {31'b0, ld_conflict}, 32'd1);
    ld_addr = 32'h204;
    #1;
    check("ld_miss", {31'b0, ld_conflict}, 32'd0);
    ld_addr   = 32'h200;
    mem_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_req",   {31'b0, mem_req},     32'd0);
    check("rst_async_empty", {31'b0, empty},       32'd1);
    check("rst_async_ld",    {31'b0, ld_conflict}, 32'd0);
    idle();
    reset = 1'b0;
    idle();
    check("post_rst_ready", {31'b0, st_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
